// File: rtl/line_ring_ctrl.sv
// Slot/pointer sequencer for the 8-line PAL->HD ring buffer: write side follows PAL
// capture strobes, read side follows HD scan-out strobes, re-phased on each field start.
module line_ring_ctrl #(
    parameter int SLOTS       = 8,
    parameter int SLOT_AW     = 11,
    parameter int ADDR_W      = 14,
    parameter int LONG_START  = 4,
    parameter int SHORT_START = 6,
    parameter int HOFF_BIAS   = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr_line,
    input  logic                       i_wr_pix,
    input  logic                       i_rd_line,
    input  logic                       i_rd_pix,
    input  logic                       i_field_start,
    input  logic [7:0]                 i_hoffset,
    output logic [ADDR_W-1:0]          o_wr_addr,
    output logic                       o_wr_en,
    output logic [ADDR_W-1:0]          o_rd_addr,
    output logic [$clog2(SLOTS)-1:0]   o_wr_slot,
    output logic [$clog2(SLOTS)-1:0]   o_rd_slot,
    output logic [$clog2(SLOTS):0]     o_fill,
    output logic                       o_long_frame,
    output logic [10:0]                o_line_cnt,
    output logic                       o_overrun,
    output logic                       o_underrun
);

    localparam int SLOT_W = $clog2(SLOTS);
    localparam int CNT_W  = 11;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [SLOT_W:0]   FILL_MAX = (SLOT_W+1)'(SLOTS - 1);

    function automatic logic [SLOT_AW-1:0] read_offset(input logic [7:0] hoff);
        return SLOT_AW'(32'(hoff) - 32'(HOFF_BIAS));
    endfunction

    // Pixel pointers wrap inside their slot; the slot bits are never carried into.
    function automatic logic [ADDR_W-1:0] in_slot_inc(input logic [ADDR_W-1:0] addr);
        logic [SLOT_AW-1:0] low;
        low = addr[SLOT_AW-1:0] + SLOT_AW'(1);
        return {addr[ADDR_W-1:SLOT_AW], low};
    endfunction

    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [SLOT_W-1:0] wr_slot_nxt;
    logic [SLOT_W-1:0] rd_slot_nxt;
    logic [SLOT_W:0]   fill_nxt;
    logic [CNT_W-1:0]  line_cnt_nxt;
    logic [CNT_W-1:0]  prev_cnt;
    logic [CNT_W-1:0]  prev_cnt_nxt;
    logic              long_nxt;
    logic              wr_en_nxt;
    logic              overrun_nxt;
    logic              underrun_nxt;
    logic [SLOT_AW-1:0] rd_off;

    always_comb begin
        wr_addr_nxt  = o_wr_addr;
        rd_addr_nxt  = o_rd_addr;
        wr_slot_nxt  = o_wr_slot;
        rd_slot_nxt  = o_rd_slot;
        fill_nxt     = o_fill;
        line_cnt_nxt = o_line_cnt;
        prev_cnt_nxt = prev_cnt;
        long_nxt     = o_long_frame;
        wr_en_nxt    = 1'b0;
        overrun_nxt  = 1'b0;
        underrun_nxt = 1'b0;
        rd_off       = read_offset(i_hoffset);

        if (i_field_start) begin
            long_nxt     = (o_line_cnt > prev_cnt);
            prev_cnt_nxt = o_line_cnt;
            wr_slot_nxt  = long_nxt ? SLOT_W'(LONG_START) : SLOT_W'(SHORT_START);
            rd_slot_nxt  = '0;
            fill_nxt     = '0;
            line_cnt_nxt = '0;
            wr_addr_nxt  = {wr_slot_nxt, {SLOT_AW{1'b0}}};
            rd_addr_nxt  = {rd_slot_nxt, rd_off};
        end else begin
            // o_wr_en high means the previous pixel was written this cycle; step past it now.
            if (i_wr_line) begin
                wr_slot_nxt = o_wr_slot + 1'b1;
                wr_addr_nxt = {wr_slot_nxt, {SLOT_AW{1'b0}}};
                if (o_line_cnt != CNT_MAX) begin
                    line_cnt_nxt = o_line_cnt + 1'b1;
                end
            end else begin
                if (o_wr_en) begin
                    wr_addr_nxt = in_slot_inc(o_wr_addr);
                end
                wr_en_nxt = i_wr_pix;
            end

            if (i_rd_line) begin
                if ((o_fill != '0) || i_wr_line) begin
                    rd_slot_nxt = o_rd_slot + 1'b1;
                end
                rd_addr_nxt = {rd_slot_nxt, rd_off};
            end else if (i_rd_pix) begin
                rd_addr_nxt = in_slot_inc(o_rd_addr);
            end

            case ({i_wr_line, i_rd_line})
                2'b10: begin
                    if (o_fill == FILL_MAX) begin
                        overrun_nxt = 1'b1;
                    end else begin
                        fill_nxt = o_fill + 1'b1;
                    end
                end
                2'b01: begin
                    if (o_fill == '0) begin
                        underrun_nxt = 1'b1;
                    end else begin
                        fill_nxt = o_fill - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_wr_addr    <= '0;
            o_rd_addr    <= '0;
            o_wr_slot    <= '0;
            o_rd_slot    <= '0;
            o_fill       <= '0;
            o_line_cnt   <= '0;
            prev_cnt     <= '0;
            o_long_frame <= 1'b0;
            o_wr_en      <= 1'b0;
            o_overrun    <= 1'b0;
            o_underrun   <= 1'b0;
        end else begin
            o_wr_addr    <= wr_addr_nxt;
            o_rd_addr    <= rd_addr_nxt;
            o_wr_slot    <= wr_slot_nxt;
            o_rd_slot    <= rd_slot_nxt;
            o_fill       <= fill_nxt;
            o_line_cnt   <= line_cnt_nxt;
            prev_cnt     <= prev_cnt_nxt;
            o_long_frame <= long_nxt;
            o_wr_en      <= wr_en_nxt;
            o_overrun    <= overrun_nxt;
            o_underrun   <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_line_ring_ctrl.sv
// Scoreboard bench for line_ring_ctrl: a behavioural ring model queues the expected
// outputs per driven cycle; a monitor pops and compares them after each rising edge.
module tb_line_ring_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_wr_line, i_wr_pix, i_rd_line, i_rd_pix, i_field_start;
    logic [7:0]  i_hoffset;
    logic [13:0] o_wr_addr, o_rd_addr;
    logic        o_wr_en;
    logic [2:0]  o_wr_slot, o_rd_slot;
    logic [3:0]  o_fill;
    logic        o_long_frame;
    logic [10:0] o_line_cnt;
    logic        o_overrun, o_underrun;

    line_ring_ctrl dut (
        .clk(clk), .reset(reset),
        .i_wr_line(i_wr_line), .i_wr_pix(i_wr_pix), .i_rd_line(i_rd_line),
        .i_rd_pix(i_rd_pix), .i_field_start(i_field_start), .i_hoffset(i_hoffset),
        .o_wr_addr(o_wr_addr), .o_wr_en(o_wr_en), .o_rd_addr(o_rd_addr),
        .o_wr_slot(o_wr_slot), .o_rd_slot(o_rd_slot), .o_fill(o_fill),
        .o_long_frame(o_long_frame), .o_line_cnt(o_line_cnt),
        .o_overrun(o_overrun), .o_underrun(o_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int wr_addr, wr_en, rd_addr, wr_slot, rd_slot, fill, lng, cnt, ovr, und;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_pass = 0;

    // ring model state (slot numbers and in-slot offsets kept separately)
    int m_wr_slot, m_wr_off, m_rd_slot, m_rd_off, m_fill, m_cnt, m_prev, m_long;
    int m_wr_en, m_ovr, m_und;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_wr_slot = 0; m_wr_off = 0; m_rd_slot = 0; m_rd_off = 0; m_fill = 0;
        m_cnt = 0; m_prev = 0; m_long = 0; m_wr_en = 0; m_ovr = 0; m_und = 0;
    endtask

    task automatic model_step(input bit fs, wl, wp, rl, rp, input int hoff);
        int off;
        int was_en;
        off = (((hoff - 128) % 2048) + 2048) % 2048;
        was_en = m_wr_en;
        m_ovr = 0; m_und = 0;
        if (fs) begin
            m_long = (m_cnt > m_prev) ? 1 : 0;
            m_prev = m_cnt;
            m_wr_slot = m_long ? 4 : 6;
            m_wr_off = 0; m_rd_slot = 0; m_rd_off = off;
            m_fill = 0; m_cnt = 0; m_wr_en = 0;
        end else begin
            if (wl) begin
                m_wr_slot = (m_wr_slot + 1) % 8;
                m_wr_off = 0;
                if (m_cnt < 2047) m_cnt++;
                m_wr_en = 0;
            end else begin
                if (was_en) m_wr_off = (m_wr_off + 1) % 2048;
                m_wr_en = wp;
            end
            if (rl) begin
                if (m_fill > 0 || wl) m_rd_slot = (m_rd_slot + 1) % 8;
                m_rd_off = off;
            end else if (rp) begin
                m_rd_off = (m_rd_off + 1) % 2048;
            end
            if (wl && !rl) begin
                if (m_fill == 7) m_ovr = 1; else m_fill++;
            end
            if (rl && !wl) begin
                if (m_fill == 0) m_und = 1; else m_fill--;
            end
        end
    endtask

    // Drive one clock of strobes, push the model's prediction, return just after the edge.
    task automatic cyc(input string tag, input bit fs, wl, wp, rl, rp, input int hoff);
        exp_t e;
        @(negedge clk);
        i_field_start = fs; i_wr_line = wl; i_wr_pix = wp;
        i_rd_line = rl; i_rd_pix = rp; i_hoffset = 8'(hoff);
        model_step(fs, wl, wp, rl, rp, hoff);
        e.tag = tag;
        e.wr_addr = m_wr_slot * 2048 + m_wr_off; e.wr_en = m_wr_en;
        e.rd_addr = m_rd_slot * 2048 + m_rd_off;
        e.wr_slot = m_wr_slot; e.rd_slot = m_rd_slot; e.fill = m_fill;
        e.lng = m_long; e.cnt = m_cnt; e.ovr = m_ovr; e.und = m_und;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".wr_addr"}, int'(o_wr_addr), 0);
        chk({tag, ".wr_en"},   int'(o_wr_en), 0);
        chk({tag, ".rd_addr"}, int'(o_rd_addr), 0);
        chk({tag, ".wr_slot"}, int'(o_wr_slot), 0);
        chk({tag, ".rd_slot"}, int'(o_rd_slot), 0);
        chk({tag, ".fill"},    int'(o_fill), 0);
        chk({tag, ".long"},    int'(o_long_frame), 0);
        chk({tag, ".cnt"},     int'(o_line_cnt), 0);
        chk({tag, ".ovr"},     int'(o_overrun), 0);
        chk({tag, ".und"},     int'(o_underrun), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".wr_addr"}, int'(o_wr_addr), e.wr_addr);
                chk({e.tag, ".wr_en"},   int'(o_wr_en), e.wr_en);
                chk({e.tag, ".rd_addr"}, int'(o_rd_addr), e.rd_addr);
                chk({e.tag, ".wr_slot"}, int'(o_wr_slot), e.wr_slot);
                chk({e.tag, ".rd_slot"}, int'(o_rd_slot), e.rd_slot);
                chk({e.tag, ".fill"},    int'(o_fill), e.fill);
                chk({e.tag, ".long"},    int'(o_long_frame), e.lng);
                chk({e.tag, ".cnt"},     int'(o_line_cnt), e.cnt);
                chk({e.tag, ".ovr"},     int'(o_overrun), e.ovr);
                chk({e.tag, ".und"},     int'(o_underrun), e.und);
            end
        end
    end

    initial begin : stim
        reset = 1'b1;
        i_wr_line = 0; i_wr_pix = 0; i_rd_line = 0; i_rd_pix = 0;
        i_field_start = 0; i_hoffset = 8'h80;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("rst");
        reset = 1'b0;

        // three written lines, one read line
        repeat (3) cyc("wline", 0, 1, 0, 0, 0, 8'h80);
        chk("t1.wr_slot", int'(o_wr_slot), 3);
        chk("t1.fill", int'(o_fill), 3);
        chk("t1.wr_addr", int'(o_wr_addr), 14'h1800);
        cyc("rline", 0, 0, 0, 1, 0, 8'h80);
        chk("t1.rd_slot", int'(o_rd_slot), 1);
        chk("t1.fill2", int'(o_fill), 2);

        // read offset and in-slot wrap of the start offset
        cyc("rline90", 0, 0, 0, 1, 0, 8'h90);
        chk("t2.rd_addr90", int'(o_rd_addr), 14'h1010);
        cyc("rline00", 0, 0, 0, 1, 0, 8'h00);
        chk("t2.rd_addr00", int'(o_rd_addr), 14'h1F80);
        repeat (128) cyc("rpix", 0, 0, 0, 0, 1, 8'h00);
        chk("t2.rd_wrap", int'(o_rd_addr), 14'h1800);
        cyc("rpix_line", 0, 0, 0, 1, 1, 8'h90);
        chk("t2.underrun", int'(o_underrun), 1);
        chk("t2.rd_held", int'(o_rd_slot), 3);

        // walk the writer to slot 1, then fill the whole slot with pixels
        repeat (6) cyc("wline", 0, 1, 0, 0, 0, 8'h80);
        chk("t3.base", int'(o_wr_addr), 14'h0800);
        repeat (2047) cyc("wpix", 0, 0, 1, 0, 0, 8'h80);
        cyc("idle", 0, 0, 0, 0, 0, 8'h80);
        chk("t3.addr_last", int'(o_wr_addr), 14'h0FFF);
        cyc("wpix_last", 0, 0, 1, 0, 0, 8'h80);
        chk("t3.wr_en", int'(o_wr_en), 1);
        chk("t3.wr_at", int'(o_wr_addr), 14'h0FFF);
        cyc("idle", 0, 0, 0, 0, 0, 8'h80);
        chk("t3.wrap", int'(o_wr_addr), 14'h0800);
        cyc("pix_line", 0, 1, 1, 0, 0, 8'h80);
        chk("t3.pix_dropped", int'(o_wr_en), 0);

        // overrun then underrun
        cyc("fs", 1, 0, 0, 0, 0, 8'h80);
        repeat (7) cyc("wline", 0, 1, 0, 0, 0, 8'h80);
        chk("t4.fill7", int'(o_fill), 7);
        chk("t4.no_ovr", int'(o_overrun), 0);
        cyc("wline8", 0, 1, 0, 0, 0, 8'h80);
        chk("t4.ovr", int'(o_overrun), 1);
        chk("t4.fill_hold", int'(o_fill), 7);
        repeat (7) cyc("rline", 0, 0, 0, 1, 0, 8'h80);
        chk("t4.fill0", int'(o_fill), 0);
        cyc("rline_empty", 0, 0, 0, 1, 0, 8'h80);
        chk("t4.und", int'(o_underrun), 1);
        chk("t4.rd_held", int'(o_rd_slot), 7);
        cyc("both", 0, 1, 0, 1, 0, 8'h80);
        chk("t4.both_fill", int'(o_fill), 0);
        chk("t4.both_rd", int'(o_rd_slot), 0);

        // interlace phasing: 313, 312, 313 lines
        cyc("fs", 1, 0, 0, 0, 0, 8'h80);
        repeat (313) cyc("wline", 0, 1, 0, 0, 0, 8'h80);
        chk("t5.cnt313", int'(o_line_cnt), 313);
        cyc("fs313", 1, 0, 0, 0, 0, 8'h80);
        chk("t5.long_a", int'(o_long_frame), 1);
        chk("t5.slot_a", int'(o_wr_slot), 4);
        chk("t5.fill_a", int'(o_fill), 0);
        repeat (312) cyc("wline", 0, 1, 0, 0, 0, 8'h80);
        cyc("fs312", 1, 0, 0, 0, 0, 8'h80);
        chk("t5.long_b", int'(o_long_frame), 0);
        chk("t5.slot_b", int'(o_wr_slot), 6);
        chk("t5.rd_b", int'(o_rd_slot), 0);
        repeat (313) cyc("wline", 0, 1, 0, 1, 0, 8'h80);
        cyc("fs313b", 1, 0, 0, 0, 0, 8'h80);
        chk("t5.long_c", int'(o_long_frame), 1);
        chk("t5.slot_c", int'(o_wr_slot), 4);
        chk("t5.cnt_c", int'(o_line_cnt), 0);

        // line counter saturation
        repeat (2050) cyc("wline", 0, 1, 0, 0, 0, 8'h80);
        chk("t5.sat", int'(o_line_cnt), 2047);

        // field start beats simultaneous strobes
        cyc("fs_all", 1, 1, 1, 1, 1, 8'h90);
        chk("t6.wr_addr", int'(o_wr_addr), 14'h2000);
        chk("t6.rd_addr", int'(o_rd_addr), 14'h0010);
        chk("t6.fill", int'(o_fill), 0);
        chk("t6.long", int'(o_long_frame), 1);

        // asynchronous reset in the middle of a line
        cyc("wline", 0, 1, 0, 0, 0, 8'h80);
        cyc("wpix", 0, 0, 1, 0, 0, 8'h80);
        #1 reset = 1'b1;
        #1 check_zero("midrst");
        i_wr_line = 0; i_wr_pix = 0; i_rd_line = 0; i_rd_pix = 0; i_field_start = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc("fs_after_rst", 1, 0, 0, 0, 0, 8'h80);
        chk("t6.slot_after_rst", int'(o_wr_slot), 6);
        cyc("idle", 0, 0, 0, 0, 0, 8'h80);

        repeat (3) @(posedge clk);
        #2 chk("sb_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
